// File: rtl/fft_radix2_iter.sv
// Iterative in-place radix-2 DIT FFT: real samples load serially (bit-reversed),
// one butterfly per enabled cycle, complex bins stream out in natural order.
module fft_radix2_iter #(
    parameter int LOG2N = 3,
    parameter int W     = 16,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W+LOG2N-1:0]   out_re,
    output logic [W+LOG2N-1:0]   out_im,
    output logic [LOG2N-1:0]     out_index,
    output logic                 out_last
);
    localparam int N  = 1 << LOG2N;
    localparam int OW = W + LOG2N;
    localparam int IW = W + LOG2N + 1;
    localparam int SW = IW + 1;
    localparam int PW = IW + 17;

    localparam logic [LOG2N-1:0] IDX_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-1:0] IDX_LAST = {LOG2N{1'b1}};
    localparam logic [LOG2N-2:0] BF_ZERO  = {(LOG2N-1){1'b0}};
    localparam logic [LOG2N-2:0] BF_LAST  = {(LOG2N-1){1'b1}};
    localparam logic [2:0]       ST_DONE  = 3'(LOG2N);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;
    logic [LOG2N-1:0] cnt_r, cnt_nxt_s, out_sel_s;
    logic [2:0]       stage_r;
    logic [LOG2N-2:0] bfly_r;
    logic             in_fire_s, out_fire_s, compute_done_s;

    logic signed [IW-1:0] mem_re [N];
    logic signed [IW-1:0] mem_im [N];

    logic [LOG2N-1:0] j_s, h_s, mask_s, a_s, b_s, t_s;
    logic [3:0]       t4_s;
    logic [2:0]       rom_s;
    logic signed [15:0]   wr_s, wi_s;
    logic signed [IW-1:0] ar_s, ai_s, br_s, bi_s, pr_s, pi_s;
    logic signed [PW-1:0] pr_full_s, pi_full_s;
    logic signed [IW-1:0] top_re_s, top_im_s, bot_re_s, bot_im_s;
    logic signed [IW-1:0] sel_re_s, sel_im_s;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Q1.14 cos(2*pi*i/16)
    function automatic logic signed [15:0] tw_cos(input logic [2:0] i);
        case (i)
            3'd0:    tw_cos = 16'sd16384;
            3'd1:    tw_cos = 16'sd15137;
            3'd2:    tw_cos = 16'sd11585;
            3'd3:    tw_cos = 16'sd6270;
            3'd4:    tw_cos = 16'sd0;
            3'd5:    tw_cos = -16'sd6270;
            3'd6:    tw_cos = -16'sd11585;
            3'd7:    tw_cos = -16'sd15137;
            default: tw_cos = 16'sd0;
        endcase
    endfunction

    // Q1.14 -sin(2*pi*i/16)
    function automatic logic signed [15:0] tw_nsin(input logic [2:0] i);
        case (i)
            3'd0:    tw_nsin = 16'sd0;
            3'd1:    tw_nsin = -16'sd6270;
            3'd2:    tw_nsin = -16'sd11585;
            3'd3:    tw_nsin = -16'sd15137;
            3'd4:    tw_nsin = -16'sd16384;
            3'd5:    tw_nsin = -16'sd15137;
            3'd6:    tw_nsin = -16'sd11585;
            3'd7:    tw_nsin = -16'sd6270;
            default: tw_nsin = 16'sd0;
        endcase
    endfunction

    function automatic logic signed [IW-1:0] fold(input logic signed [SW-1:0] v);
        if (SCALE == 1) begin
            fold = IW'(v >>> 1'b1);
        end else begin
            fold = IW'(v);
        end
    endfunction

    assign in_fire_s      = en & in_valid & in_ready;
    assign out_fire_s     = en & out_valid & out_ready;
    assign compute_done_s = (stage_r == ST_DONE);
    assign cnt_nxt_s      = cnt_r + IDX_ONE;

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (in_fire_s && (cnt_r == IDX_LAST)) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_COMPUTE: begin
                if (en && compute_done_s) begin
                    state_nxt_s = ST_OUTPUT;
                end else begin
                    state_nxt_s = ST_COMPUTE;
                end
            end
            ST_OUTPUT: begin
                if (out_fire_s && out_last) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_OUTPUT;
                end
            end
            default: state_nxt_s = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_LOAD;
        end else if (en) begin
            state_r <= state_nxt_s;
        end
    end

    // Pair (a, a+h) and twiddle index for butterfly j of the current stage
    always_comb begin
        j_s    = {1'b0, bfly_r};
        h_s    = IDX_ONE << stage_r;
        mask_s = h_s - IDX_ONE;
        a_s    = ((j_s >> stage_r) << (stage_r + 3'd1)) | (j_s & mask_s);
        b_s    = a_s | h_s;
        t_s    = (j_s & mask_s) << (3'(LOG2N - 1) - stage_r);
        t4_s   = 4'(t_s);
        rom_s  = 3'(t4_s << (4 - LOG2N));
    end

    // Butterfly datapath; t=0 skips the multiplier so its truncation never applies
    always_comb begin
        ar_s = mem_re[a_s];
        ai_s = mem_im[a_s];
        br_s = mem_re[b_s];
        bi_s = mem_im[b_s];
        wr_s = tw_cos(rom_s);
        wi_s = tw_nsin(rom_s);
        pr_full_s = PW'(br_s) * PW'(wr_s) - PW'(bi_s) * PW'(wi_s);
        pi_full_s = PW'(br_s) * PW'(wi_s) + PW'(bi_s) * PW'(wr_s);
        if (t_s == IDX_ZERO) begin
            pr_s = br_s;
            pi_s = bi_s;
        end else begin
            pr_s = IW'(pr_full_s >>> 5'd14);
            pi_s = IW'(pi_full_s >>> 5'd14);
        end
        top_re_s = fold(SW'(ar_s) + SW'(pr_s));
        top_im_s = fold(SW'(ai_s) + SW'(pi_s));
        bot_re_s = fold(SW'(ar_s) - SW'(pr_s));
        bot_im_s = fold(SW'(ai_s) - SW'(pi_s));
    end

    // Bin read-out selection: bin 0 on entry to OUTPUT, next bin on each transfer
    always_comb begin
        if (state_r == ST_OUTPUT) begin
            out_sel_s = cnt_nxt_s;
        end else begin
            out_sel_s = IDX_ZERO;
        end
        sel_re_s = mem_re[out_sel_s];
        sel_im_s = mem_im[out_sel_s];
    end

    // Sample buffer: bit-reversed load, then in-place butterfly write-back
    always_ff @(posedge clk) begin
        if (in_fire_s && (state_r == ST_LOAD)) begin
            mem_re[bitrev(cnt_r)] <= IW'($signed(in_data));
            mem_im[bitrev(cnt_r)] <= {IW{1'b0}};
        end else if (en && (state_r == ST_COMPUTE) && !compute_done_s) begin
            mem_re[a_s] <= top_re_s;
            mem_im[a_s] <= top_im_s;
            mem_re[b_s] <= bot_re_s;
            mem_im[b_s] <= bot_im_s;
        end
    end

    // Counters, handshake flags and registered bin outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r     <= IDX_ZERO;
            stage_r   <= 3'd0;
            bfly_r    <= BF_ZERO;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_re    <= {OW{1'b0}};
            out_im    <= {OW{1'b0}};
            out_index <= IDX_ZERO;
            out_last  <= 1'b0;
        end else if (en) begin
            case (state_r)
                ST_LOAD: begin
                    if (in_fire_s) begin
                        if (cnt_r == IDX_LAST) begin
                            cnt_r    <= IDX_ZERO;
                            in_ready <= 1'b0;
                            stage_r  <= 3'd0;
                            bfly_r   <= BF_ZERO;
                        end else begin
                            cnt_r <= cnt_nxt_s;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (compute_done_s) begin
                        out_valid <= 1'b1;
                        out_re    <= OW'(sel_re_s);
                        out_im    <= OW'(sel_im_s);
                        out_index <= IDX_ZERO;
                        out_last  <= 1'b0;
                        cnt_r     <= IDX_ZERO;
                    end else if (bfly_r == BF_LAST) begin
                        bfly_r  <= BF_ZERO;
                        stage_r <= stage_r + 3'd1;
                    end else begin
                        bfly_r <= bfly_r + {{(LOG2N-2){1'b0}}, 1'b1};
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            in_ready  <= 1'b1;
                            cnt_r     <= IDX_ZERO;
                        end else begin
                            out_re    <= OW'(sel_re_s);
                            out_im    <= OW'(sel_im_s);
                            out_index <= cnt_nxt_s;
                            out_last  <= (cnt_nxt_s == IDX_LAST);
                            cnt_r     <= cnt_nxt_s;
                        end
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_radix2_iter.sv
// Scoreboard bench for fft_radix2_iter: 8-point (full growth and scaled), 4- and 16-point builds.
module tb_fft_radix2_iter;
    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, out_ready;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, ol0, ol1, ol2, ol3;
    logic [18:0] re0, im0, re1, im1;
    logic [17:0] re2, im2;
    logic [19:0] re3, im3;
    logic [2:0]  ix0, ix1;
    logic [1:0]  ix2;
    logic [3:0]  ix3;

    int tests = 0;
    int fails = 0;
    int xs[16], er[16], ei[16];
    exp_t q0[$], q1[$], q2[$], q3[$];

    always #5 clk = ~clk;

    fft_radix2_iter #(.LOG2N(3), .W(16), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_re(re0), .out_im(im0), .out_index(ix0), .out_last(ol0));
    fft_radix2_iter #(.LOG2N(3), .W(16), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_re(re1), .out_im(im1), .out_index(ix1), .out_last(ol1));
    fft_radix2_iter #(.LOG2N(2), .W(16), .SCALE(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid[2]), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_re(re2), .out_im(im2), .out_index(ix2), .out_last(ol2));
    fft_radix2_iter #(.LOG2N(4), .W(16), .SCALE(0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid[3]), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_re(re3), .out_im(im3), .out_index(ix3), .out_last(ol3));

    task automatic cmp(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Monitor side: pop the oldest expected bin of DUT d and compare
    task automatic chk(input int d, input int re, input int im, input int idx, input bit last);
        exp_t e;
        bit   got = 1'b1;
        case (d)
            0: if (q0.size() > 0) e = q0.pop_front(); else got = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else got = 1'b0;
            2: if (q2.size() > 0) e = q2.pop_front(); else got = 1'b0;
            default: if (q3.size() > 0) e = q3.pop_front(); else got = 1'b0;
        endcase
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL dut%0d_unexpected_bin: got idx=%0d re=%0d im=%0d, required no output", d, idx, re, im);
        end else if (re != e.re || im != e.im || idx != e.idx || last != e.last) begin
            fails++;
            $display("FAIL dut%0d_bin: got idx=%0d re=%0d im=%0d last=%0d, required idx=%0d re=%0d im=%0d last=%0d",
                     d, idx, re, im, last, e.idx, e.re, e.im, e.last);
        end
    endtask

    always @(negedge clk) if (rst && en && out_ready && ov0) chk(0, int'($signed(re0)), int'($signed(im0)), int'(ix0), ol0);
    always @(negedge clk) if (rst && en && out_ready && ov1) chk(1, int'($signed(re1)), int'($signed(im1)), int'(ix1), ol1);
    always @(negedge clk) if (rst && en && out_ready && ov2) chk(2, int'($signed(re2)), int'($signed(im2)), int'(ix2), ol2);
    always @(negedge clk) if (rst && en && out_ready && ov3) chk(3, int'($signed(re3)), int'($signed(im3)), int'(ix3), ol3);

    function automatic bit rdy(input int d);
        case (d)
            0: rdy = ir0;
            1: rdy = ir1;
            2: rdy = ir2;
            default: rdy = ir3;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind: 0 impulse, 1 dc, 2 tone (bins 2/6), 3 alternating, 4 impulse with per-stage halving
    task automatic prep(input int kind, input int n, input int amp);
        for (int i = 0; i < 16; i++) begin
            xs[i] = 0;
            er[i] = 0;
            ei[i] = 0;
        end
        case (kind)
            0: begin xs[0] = amp; for (int i = 0; i < n; i++) er[i] = amp; end
            1: begin for (int i = 0; i < n; i++) xs[i] = amp; er[0] = amp * n; end
            2: begin
                xs[1] = 1000; xs[3] = -1000; xs[5] = 1000; xs[7] = -1000;
                ei[2] = -4000; ei[6] = 4000;
            end
            3: begin for (int i = 0; i < n; i++) xs[i] = (i % 2 == 0) ? 100 : -100; er[4] = 800; end
            4: begin xs[0] = amp; for (int i = 0; i < n; i++) er[i] = amp / n; end
            default: ;
        endcase
    endtask

    task automatic push_exp(input int d, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.re = er[k];
            e.im = ei[k];
            e.idx = k;
            e.last = (k == n - 1);
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                2: q2.push_back(e);
                default: q3.push_back(e);
            endcase
        end
    endtask

    task automatic send(input int d, input int n);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            in_valid[d] = 1'b1;
            in_data = 16'(xs[i]);
            acc = 1'b0;
            guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = rdy(d) && en && rst;
                @(posedge clk);
                #1;
                guard++;
                if (!acc && guard > 300) begin
                    tests++;
                    fails++;
                    $display("FAIL send_timeout: dut%0d sample %0d not accepted, required acceptance", d, i);
                    in_valid[d] = 1'b0;
                    return;
                end
            end
        end
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && g < 3000) begin
            tick(1);
            g++;
        end
        cmp("bins_outstanding", q0.size() + q1.size() + q2.size() + q3.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        in_valid = 4'b0000;
        in_data = 16'd0;
        tick(2);
        cmp("rst_in_ready", int'(ir0), 1);
        cmp("rst_out_valid", int'(ov0), 0);
        cmp("rst_out_re", int'(re0), 0);
        cmp("rst_out_im", int'(im0), 0);
        cmp("rst_out_index", int'(ix0), 0);
        cmp("rst_out_last", int'(ol0), 0);
        cmp("rst_in_ready_n16", int'(ir3), 1);
        rst = 1'b1;
        tick(1);

        // Impulse with 5 cycles of backpressure on bin 3
        prep(0, 8, 256);
        push_exp(0, 8);
        send(0, 8);
        k = 0;
        while (!(ov0 && ix0 == 3'd3) && k < 100) begin
            tick(1);
            k++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(1);
            cmp("bp_hold_valid", int'(ov0), 1);
            cmp("bp_hold_index", int'(ix0), 3);
            cmp("bp_hold_re", int'($signed(re0)), 256);
        end
        out_ready = 1'b1;
        drain();

        // DC: out_valid must rise on the 13th edge after the x7 handshake
        prep(1, 8, 256);
        push_exp(0, 8);
        send(0, 8);
        k = 0;
        while (!ov0 && k < 40) begin
            tick(1);
            k++;
        end
        cmp("dc_latency", k, 13);
        drain();

        prep(2, 8, 0);
        push_exp(0, 8);
        send(0, 8);
        drain();

        prep(3, 8, 0);
        push_exp(0, 8);
        send(0, 8);
        drain();

        // Tone with en dropped for 3 cycles in the middle of COMPUTE
        prep(2, 8, 0);
        push_exp(0, 8);
        send(0, 8);
        tick(4);
        en = 1'b0;
        tick(3);
        en = 1'b1;
        drain();

        // Alternating with in_valid pulses while computing
        prep(3, 8, 0);
        push_exp(0, 8);
        send(0, 8);
        tick(2);
        in_valid[0] = 1'b1;
        in_data = 16'h7fff;
        #1;
        cmp("in_ready_in_compute", int'(ir0), 0);
        tick(3);
        in_valid[0] = 1'b0;
        drain();

        // Reset during COMPUTE, then a clean tone frame
        prep(2, 8, 0);
        send(0, 8);
        tick(4);
        cmp("compute_in_ready", int'(ir0), 0);
        rst = 1'b0;
        #1;
        cmp("midrst_out_valid", int'(ov0), 0);
        cmp("midrst_in_ready", int'(ir0), 1);
        tick(1);
        rst = 1'b1;
        tick(2);
        push_exp(0, 8);
        send(0, 8);
        drain();

        // Back-to-back frames: impulse then DC
        prep(0, 8, 256);
        push_exp(0, 8);
        send(0, 8);
        prep(1, 8, 256);
        push_exp(0, 8);
        send(0, 8);
        drain();

        prep(4, 8, 256);
        push_exp(1, 8);
        send(1, 8);
        drain();

        prep(0, 4, 256);
        push_exp(2, 4);
        send(2, 4);
        drain();

        prep(0, 16, 256);
        push_exp(3, 16);
        send(3, 16);
        drain();

        prep(1, 16, 100);
        push_exp(3, 16);
        send(3, 16);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
